// File: rtl/icetap_scan_readout.sv
// icetap_scan_readout
//   Scan-domain serializer for recorded sample data. Fetches samples from the
//   capture RAM through a first/next request handshake. It zero-pads each sample
//   to a whole number of CHUNK_BITS and shifts it out MSB-first. A one-entry hold
//   buffer prefetches the next sample, so the bit stream has no gaps.
//
// Ports
//   scan_clk          clock
//   scan_reset        synchronous active-high reset
//   data_shift_update start/restart a readout; samples nr_samples
//   data_shift_ena    shift one bit out
//   data_shift_data   serial data, MSB-first (0 when nothing is loaded)
//   nr_samples        number of samples to read out
//   read_req_first    one-cycle pulse: read the first sample
//   read_req_next     one-cycle pulse: read the next sample
//   read_data         RAM data, valid READ_LATENCY cycles after a request
//   busy              readout in progress
//   done              all samples shifted out (sticky until update/reset)
//   underrun          sticky: shift requested while nothing was loaded
//   samples_shifted   count of fully shifted samples
module icetap_scan_readout #(
    parameter int unsigned NR_SIGNALS   = 16,
    parameter int unsigned RECORD_DEPTH = 256,
    parameter int unsigned CHUNK_BITS   = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                          scan_clk,
    input  logic                          scan_reset,
    input  logic                          data_shift_update,
    input  logic                          data_shift_ena,
    output logic                          data_shift_data,
    input  logic [$clog2(RECORD_DEPTH):0] nr_samples,
    output logic                          read_req_first,
    output logic                          read_req_next,
    input  logic [NR_SIGNALS-1:0]         read_data,
    output logic                          busy,
    output logic                          done,
    output logic                          underrun,
    output logic [$clog2(RECORD_DEPTH):0] samples_shifted
);

    localparam int unsigned CW = $clog2(RECORD_DEPTH) + 1;
    localparam int unsigned W  = ((NR_SIGNALS + CHUNK_BITS - 1) / CHUNK_BITS) * CHUNK_BITS;
    localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StFetch, StShift, StDone} state_e;

    state_e                  state_q;
    logic [W-1:0]            sr_q;
    logic                    sr_loaded_q;
    logic [BW-1:0]           bit_cnt_q;
    logic [W-1:0]            hold_q;
    logic                    hold_valid_q;
    logic [CW-1:0]           fetched_q;
    logic [CW-1:0]           nr_q;
    // One bit per cycle of read latency; the top bit marks read_data as valid.
    logic [READ_LATENCY-1:0] rd_vld_q;

    logic          shift_go;
    logic          last_bit;
    logic          capture;
    logic          load_empty;
    logic          refill;
    logic          hold_take;
    logic [CW-1:0] shifted_inc;

    always_comb begin
        shift_go    = data_shift_ena && sr_loaded_q && (state_q != StDone);
        last_bit    = (bit_cnt_q == BW'(W - 1));
        capture     = rd_vld_q[READ_LATENCY-1];
        load_empty  = !sr_loaded_q && hold_valid_q && (state_q != StDone);
        refill      = shift_go && last_bit && hold_valid_q;
        hold_take   = load_empty || refill;
        shifted_inc = samples_shifted + CW'(1);
    end

    assign data_shift_data = sr_loaded_q & sr_q[W-1];

    always_ff @(posedge scan_clk) begin
        if (scan_reset) begin
            state_q         <= StIdle;
            sr_q            <= '0;
            sr_loaded_q     <= 1'b0;
            bit_cnt_q       <= '0;
            hold_q          <= '0;
            hold_valid_q    <= 1'b0;
            fetched_q       <= '0;
            nr_q            <= '0;
            rd_vld_q        <= '0;
            read_req_first  <= 1'b0;
            read_req_next   <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            underrun        <= 1'b0;
            samples_shifted <= '0;
        end else if (data_shift_update) begin
            // Update wins over a simultaneous shift; clearing rd_vld_q drops any
            // read still in flight from the previous readout.
            nr_q            <= nr_samples;
            sr_q            <= '0;
            sr_loaded_q     <= 1'b0;
            bit_cnt_q       <= '0;
            hold_q          <= '0;
            hold_valid_q    <= 1'b0;
            rd_vld_q        <= '0;
            read_req_next   <= 1'b0;
            underrun        <= 1'b0;
            samples_shifted <= '0;
            if (nr_samples == '0) begin
                state_q        <= StDone;
                done           <= 1'b1;
                busy           <= 1'b0;
                read_req_first <= 1'b0;
                fetched_q      <= '0;
            end else begin
                state_q        <= StFetch;
                done           <= 1'b0;
                busy           <= 1'b1;
                read_req_first <= 1'b1;
                fetched_q      <= CW'(1);
            end
        end else begin
            read_req_first <= 1'b0;
            read_req_next  <= 1'b0;

            rd_vld_q[0] <= read_req_first | read_req_next;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
            end

            // Only one request is ever outstanding and it is only issued once the
            // hold buffer is empty, so capture never collides with a hold take.
            if (capture) begin
                hold_q       <= W'(read_data);
                hold_valid_q <= 1'b1;
            end

            if (load_empty) begin
                sr_q         <= hold_q;
                sr_loaded_q  <= 1'b1;
                bit_cnt_q    <= '0;
                hold_valid_q <= 1'b0;
                if (state_q == StFetch) begin
                    state_q <= StShift;
                end
            end

            if (shift_go) begin
                sr_q      <= sr_q << 1;
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (last_bit) begin
                    samples_shifted <= shifted_inc;
                    if (shifted_inc == nr_q) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                    if (hold_valid_q) begin
                        sr_q         <= hold_q;
                        bit_cnt_q    <= '0;
                        hold_valid_q <= 1'b0;
                    end else begin
                        sr_loaded_q <= 1'b0;
                    end
                end
            end

            // Prefetch as soon as the hold buffer empties.
            if (hold_take && (fetched_q < nr_q)) begin
                read_req_next <= 1'b1;
                fetched_q     <= fetched_q + CW'(1);
            end

            if (data_shift_ena && busy && !sr_loaded_q) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule
